// File: rtl/obi_sbr_mem.sv
// OBI subordinate memory: byte-masked word memory behind one A/R channel pair, in-order
// responses through a Latency-stage pipe and a bypassable FIFO. Optional macro: OBI_SBR_MEM_RANGE_ERR_EN.
module obi_sbr_mem #(
    parameter int unsigned          AddrWidth   = 32,
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          IdWidth     = 5,
    parameter int unsigned          NumWords    = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr    = '0,
    parameter int unsigned          Latency     = 1,
    parameter int unsigned          NumMaxTrans = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [IdWidth-1:0]     rid_o,
    output logic                   err_o
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned ByteOff  = $clog2(BeWidth);
    localparam int unsigned IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);
    localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } rsp_t;

    // Valid/ready: a beat transfers on a rising edge where valid && ready (A: req_i && gnt_o,
    // R: rvalid_o && rready_i); once rvalid_o is high it and its payload hold until accepted.
    logic                a_hs;
    logic                r_hs;
    logic [CntWidth-1:0] outstanding;

    // Grant is forced low while reset is asserted so nothing is accepted during reset.
    assign gnt_o = req_i && rst_ni && (outstanding < CntWidth'(NumMaxTrans));
    assign a_hs  = req_i && gnt_o;
    assign r_hs  = rvalid_o && rready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else begin
            unique case ({a_hs, r_hs})
                2'b10:   outstanding <= outstanding + CntWidth'(1);
                2'b01:   outstanding <= outstanding - CntWidth'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Address decode: offset from the base, word index wraps modulo the depth.
    logic [AddrWidth-1:0] addr_off;
    logic [IdxWidth-1:0]  word_idx;
    logic                 in_range;
    logic                 unused_addr;

    assign addr_off    = addr_i - BaseAddr;
    assign word_idx    = addr_off[ByteOff +: IdxWidth];
    assign unused_addr = ^addr_off;

`ifdef OBI_SBR_MEM_RANGE_ERR_EN
    localparam logic [AddrWidth:0] SpanBytes = (AddrWidth + 1)'(NumWords * BeWidth);
    assign in_range = (addr_i >= BaseAddr) && ({1'b0, addr_off} < SpanBytes);
`else
    assign in_range = 1'b1;
`endif

    logic [DataWidth-1:0] mem [NumWords];

    always_ff @(posedge clk_i) begin
        if (a_hs && we_i && in_range) begin
            for (int k = 0; k < BeWidth; k++) begin
                if (be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response for the current request: read data only for in-range reads.
    rsp_t new_rsp;

    always_comb begin
        new_rsp       = '0;
        new_rsp.rid   = aid_i;
        new_rsp.err   = !in_range;
        new_rsp.rdata = (we_i || !in_range) ? '0 : mem[word_idx];
    end

    // Fixed-latency pipe; the credit limit means it never has to stall.
    logic [Latency-1:0] pipe_v;
    rsp_t               pipe_q [Latency];
    logic               pipe_out_v;
    rsp_t               pipe_out;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_v <= '0;
            for (int i = 0; i < Latency; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_v[0] <= a_hs;
            pipe_q[0] <= new_rsp;
            for (int i = 1; i < Latency; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign pipe_out_v = pipe_v[Latency-1];
    assign pipe_out   = pipe_q[Latency-1];

    // Response FIFO; an arriving pipe entry is the head directly when the FIFO is empty.
    rsp_t                fifo_mem [NumMaxTrans];
    logic [PtrWidth-1:0] wptr;
    logic [PtrWidth-1:0] rptr;
    logic [CntWidth-1:0] fifo_cnt;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    rsp_t                head;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(NumMaxTrans - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign fifo_empty = (fifo_cnt == '0);
    assign push       = pipe_out_v && !(fifo_empty && rready_i);
    assign pop        = !fifo_empty && rready_i;
    assign head       = fifo_empty ? pipe_out : fifo_mem[rptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wptr] <= pipe_out;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CntWidth'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CntWidth'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rvalid_o = !fifo_empty || pipe_out_v;
    assign rdata_o  = rvalid_o ? head.rdata : '0;
    assign rid_o    = rvalid_o ? head.rid : '0;

`ifdef OBI_SBR_MEM_RANGE_ERR_EN
    assign err_o = rvalid_o && head.err;
`else
    logic unused_err;
    assign unused_err = head.err;
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_obi_sbr_mem.sv
// Bench for obi_sbr_mem (Latency 3, 4 credits, 256 words): directed steps plus random traffic
// checked against a word-array reference model and an in-order expected-response queue.
module tb_obi_sbr_mem;

    localparam int          AW      = 32;
    localparam int          DW      = 32;
    localparam int          IW      = 5;
    localparam int          NW      = 256;
    localparam int          LAT     = 3;
    localparam int          NMT     = 4;
    localparam int          TIMEOUT = 200;
    localparam logic [31:0] BASE    = 32'h0000_8000;

    logic          clk;
    logic          rst_ni;
    logic          req;
    logic          gnt;
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic [IW-1:0] aid;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic          err;

    obi_sbr_mem #(
        .AddrWidth  (AW),
        .DataWidth  (DW),
        .IdWidth    (IW),
        .NumWords   (NW),
        .BaseAddr   (BASE),
        .Latency    (LAT),
        .NumMaxTrans(NMT)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .req_i   (req),
        .gnt_o   (gnt),
        .addr_i  (addr),
        .we_i    (we),
        .be_i    (be),
        .wdata_i (wdata),
        .aid_i   (aid),
        .rvalid_o(rvalid),
        .rready_i(rready),
        .rdata_o (rdata),
        .rid_o   (rid),
        .err_o   (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [DW-1:0] model_mem [NW];
    logic [37:0]   exp_q[$];
    int            hs_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    bit            check_lat   = 1'b0;
    bit            rready_rand = 1'b0;
    logic [DW-1:0] last_rdata;
    logic [IW-1:0] last_rid;
    logic          last_err;
    logic [37:0]   mon_e;
    int            mon_h;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: byte-addressed word array with modulo wrap and optional range error.
    function automatic logic [37:0] model_step(input logic w, input logic [31:0] a,
                                               input logic [3:0] b, input logic [31:0] d,
                                               input logic [4:0] id);
        logic [31:0] off;
        int unsigned idx;
        bit          inr;
        off = a - BASE;
        idx = (off >> 2) % NW;
`ifdef OBI_SBR_MEM_RANGE_ERR_EN
        inr = (a >= BASE) && (off < NW * 4);
`else
        inr = 1'b1;
`endif
        if (!inr) return {1'b1, id, 32'h0};
        if (w) begin
            for (int k = 0; k < 4; k++) begin
                if (b[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
            end
            return {1'b0, id, 32'h0};
        end
        return {1'b0, id, model_mem[idx]};
    endfunction

    // Monitor: sample both channels on the falling edge.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL rsp_unexpected observed=rid %0h expected=no response", rid);
                end else begin
                    mon_e      = exp_q.pop_front();
                    mon_h      = hs_q.pop_front();
                    last_rdata = rdata;
                    last_rid   = rid;
                    last_err   = err;
                    check("rsp", {26'b0, err, rid, rdata}, {26'b0, mon_e});
                    if (check_lat) check("latency", 64'(cyc - mon_h), 64'(LAT));
                end
            end
            if (req && gnt) begin
                exp_q.push_back(model_step(we, addr, be, wdata, aid));
                hs_q.push_back(cyc);
                check("outstanding_bound", 64'(exp_q.size() <= NMT), 64'd1);
            end
        end
    end

    // random rready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rready_rand) rready = 1'($urandom_range(0, 1));
        end
    end

    // driver tasks (called at posedge + #1)
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [4:0] id, output int stalls);
        int n = 0;
        req = 1'b1; we = w; addr = a; be = b; wdata = d; aid = id;
        @(negedge clk);
        while (!gnt && n < TIMEOUT) begin
            n++;
            @(negedge clk);
        end
        check("grant_wait", 64'(n < TIMEOUT), 64'd1);
        stalls = n;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; be = '0; wdata = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(posedge clk);
        #1;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    int          st;
    int          stall_sum;
    int          grants;
    int          a;
    bit          g;
    logic [31:0] t3_addr;

    initial begin
        rst_ni = 1'b0; req = 1'b1; we = 1'b0; addr = BASE; be = '0; wdata = '0; aid = '0;
        rready = 1'b1;

        // reset state, request held high to show grant is suppressed
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rid", 64'(rid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        req    = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid", 64'(rvalid), 64'd0);
        @(posedge clk);
        #1;

        // fill every word at full rate
        check_lat = 1'b1;
        stall_sum = 0;
        for (int i = 0; i < NW; i++) begin
            issue(1'b1, BASE + 32'(i * 4), 4'hF, $urandom, 5'($urandom_range(0, 31)), st);
            stall_sum += st;
        end
        idle();
        wait_drain();
        check("fill_throughput", 64'(stall_sum), 64'd0);

        // T1 write then read
        issue(1'b1, BASE + 32'h100, 4'hF, 32'hDEADBEEF, 5'd3, st);
        issue(1'b0, BASE + 32'h100, 4'h0, 32'h0, 5'd4, st);
        idle();
        wait_drain();
        check("t1_rdata", 64'(last_rdata), 64'hDEADBEEF);
        check("t1_rid", 64'(last_rid), 64'd4);

        // T2 partial byte enables, then be=0 no-op
        issue(1'b1, BASE + 32'h200, 4'hF, 32'hFFFFFFFF, 5'd1, st);
        issue(1'b1, BASE + 32'h200, 4'h5, 32'h00000000, 5'd2, st);
        issue(1'b0, BASE + 32'h200, 4'h0, 32'h0, 5'd5, st);
        idle();
        wait_drain();
        check("t2_rdata", 64'(last_rdata), 64'hFF00FF00);
        issue(1'b1, BASE + 32'h200, 4'h0, 32'h12345678, 5'd6, st);
        issue(1'b0, BASE + 32'h200, 4'h0, 32'h0, 5'd7, st);
        idle();
        wait_drain();
        check("t2_be0_rdata", 64'(last_rdata), 64'hFF00FF00);

        // T3 back-pressure: credits run out, head holds
        check_lat = 1'b0;
        rready    = 1'b0;
        grants    = 0;
        a         = 0;
        t3_addr   = BASE + 32'($urandom_range(0, NW - 1) * 4);
        req = 1'b1; we = 1'b0; be = '0; addr = t3_addr; aid = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g = gnt;
            if (g) grants++;
            if (rvalid && exp_q.size() > 0) begin
                check("t3_rid_hold", 64'(rid), 64'd0);
                check("t3_rdata_hold", 64'(rdata), 64'(exp_q[0][31:0]));
            end
            @(posedge clk);
            #1;
            if (g) begin
                a++;
                aid  = 5'(a);
                addr = BASE + 32'($urandom_range(0, NW - 1) * 4);
            end
        end
        check("t3_grants", 64'(grants), 64'(NMT));
        idle();
        rready = 1'b1;
        wait_drain();
        for (int i = 4; i < 8; i++) begin
            issue(1'b0, BASE + 32'($urandom_range(0, NW - 1) * 4), 4'h0, 32'h0, 5'(i), st);
        end
        idle();
        wait_drain();

        // T4 random traffic at full rate
        check_lat = 1'b1;
        stall_sum = 0;
        for (int i = 0; i < 100; i++) begin
            issue(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, NW * 4 - 1)),
                  4'($urandom_range(0, 15)), $urandom, 5'($urandom_range(0, 31)), st);
            stall_sum += st;
        end
        idle();
        wait_drain();
        check("t4_throughput", 64'(stall_sum), 64'd0);

        // random traffic with random rready
        check_lat   = 1'b0;
        rready_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, NW * 4 - 1)),
                  4'($urandom_range(0, 15)), $urandom, 5'($urandom_range(0, 31)), st);
        end
        idle();
        rready_rand = 1'b0;
        @(posedge clk);
        #1;
        rready = 1'b1;
        wait_drain();

        // T5 reset with responses pending
        rready = 1'b0;
        issue(1'b0, BASE + 32'h10, 4'h0, 32'h0, 5'd20, st);
        issue(1'b0, BASE + 32'h14, 4'h0, 32'h0, 5'd21, st);
        idle();
        a = 0;
        @(negedge clk);
        while (!rvalid && a < 20) begin
            a++;
            @(negedge clk);
        end
        check("t5_pending", 64'(rvalid), 64'd1);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        req = 1'b1; we = 1'b0; addr = BASE; aid = 5'd22;
        exp_q.delete();
        hs_q.delete();
        @(negedge clk);
        check("t5_rst_gnt", 64'(gnt), 64'd0);
        check("t5_rst_rvalid", 64'(rvalid), 64'd0);
        check("t5_rst_rid", 64'(rid), 64'd0);
        check("t5_rst_rdata", 64'(rdata), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        idle();
        rready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_stale", 64'(rvalid), 64'd0);
        end
        @(posedge clk);
        #1;
        check_lat = 1'b1;
        issue(1'b0, BASE + 32'h100, 4'h0, 32'h0, 5'd9, st);
        idle();
        wait_drain();
        check("t5_rid", 64'(last_rid), 64'd9);

        // T6 out-of-range accesses
        issue(1'b0, BASE + 32'(NW * 4), 4'h0, 32'h0, 5'd10, st);
        idle();
        wait_drain();
`ifdef OBI_SBR_MEM_RANGE_ERR_EN
        check("t6_err", 64'(last_err), 64'd1);
        check("t6_rdata", 64'(last_rdata), 64'd0);
`else
        check("t6_err", 64'(last_err), 64'd0);
        check("t6_rdata", 64'(last_rdata), 64'(model_mem[0]));
`endif
        issue(1'b1, BASE + 32'(NW * 4 + 4), 4'hF, 32'hA5A5A5A5, 5'd11, st);
        issue(1'b0, BASE + 32'h4, 4'h0, 32'h0, 5'd12, st);
        issue(1'b0, BASE - 32'h4, 4'h0, 32'h0, 5'd13, st);
        idle();
        wait_drain();
`ifdef OBI_SBR_MEM_RANGE_ERR_EN
        check("t6_below_err", 64'(last_err), 64'd1);
`else
        check("t6_below_err", 64'(last_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
